// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory, holds the result toward decode, and honours redirects.
module ysyx_23060332_ifu #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          INST_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              kill_q, kill_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
    logic [ADDR_W-1:0] redirect_pc_c;

    // Targets are forced to word alignment; no fault is raised.
    assign redirect_pc_c = {redirect_addr_i[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            inst_q      <= '0;
            inst_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
        end
    end

    // Next-state logic; a redirect always wins over the normal flow.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (redirect_i) pc_d = redirect_pc_c;
            end
            ST_REQ: begin
                if (redirect_i) pc_d = redirect_pc_c;
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                    kill_d  = redirect_i;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_c;
                    if (imem_resp_valid) begin
                        state_d = ST_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (kill_q) begin
                        state_d = ST_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        inst_d      = imem_resp_data;
                        inst_addr_d = pc_q;
                        state_d     = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_c;
                    state_d = ST_REQ;
                end else if (inst_ready_i) begin
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid_o   = (state_q == ST_OUT);
    assign inst_o         = inst_q;
    assign inst_addr_o    = inst_addr_q;

endmodule
